period_meas: RTL
================

# period_meas

Cycle-domain period measurement stage that consumes the single-cycle edge pulse produced by the edge-detection stage. It counts clock cycles between consecutive accepted edges and presents each interval as a result word on a valid/ready output. Saturating arithmetic flags overlong intervals, and a glitch filter rejects edges that arrive too soon after the previous one. It feeds period/frequency readout and control logic in the emulated analog signal path.

## Interface
- WIDTH, 16: width of the cycle counter and the period result; must be ≥ 2.
- MIN_PERIOD, 1: minimum accepted interval in cycles; edges with interval < MIN_PERIOD are ignored. Range 1..2^WIDTH-1.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  measurement enable.
- evt  input  1  single-cycle edge pulse from the upstream edge detector.
- period_o  output  WIDTH  measured interval in cycles.
- ovf_o  output  1  the result saturated at 2^WIDTH-1.
- valid_o  output  1  result available.
- ready_i  input  1  downstream accepts the result.
- drop_o  output  1  sticky flag: at least one result was lost.

## Operation
- States: IDLE (no reference edge yet) and ARMED (counting since the last accepted edge).
- Counter `cnt`, WIDTH bits, is cleared to 0 in IDLE.
  - In ARMED, `cnt` increments every cycle and saturates at 2^WIDTH-1; it never wraps.
- IDLE, en=1, evt=1: go to ARMED and load cnt to 1. No result is produced.
- ARMED, evt=1, cnt ≥ MIN_PERIOD: accept the edge.
  - Capture period=cnt and ovf=(cnt==2^WIDTH-1).
  - Reload cnt to 1 and stay in ARMED.
- ARMED, evt=1, cnt < MIN_PERIOD: ignore the edge and keep counting.
- en=0 in any state: go to IDLE and clear cnt. A held result stays held and valid_o is unchanged.
- Accepted edges at cycles t0 and t1 produce period_o = t1 − t0.
- Output register holds one result:
  - A capture loads period_o/ovf_o and sets valid_o.
  - valid_o && ready_i clears valid_o, unless a capture occurs in the same cycle. In that case the new result loads and valid_o stays 1 (no drop).
  - A capture while valid_o=1 and ready_i=0 discards the new result, keeps the old one, and sets drop_o.
- While valid_o=1, period_o and ovf_o are stable until the handshake completes.
- drop_o clears only on reset.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - period_o=0, ovf_o=0, valid_o=0, drop_o=0.
- Latency: valid_o rises in the cycle after the accepted evt cycle.
- Throughput: one result per cycle when ready_i is held high.
- evt is used in the cycle it arrives; the block adds no input register.
- rst in mid-measurement discards the count and any held result. The first edge after reset only arms the block.
- An edge in the same cycle as en falling is ignored.
- An edge in the same cycle as en rising from IDLE arms the block.
- ready_i is ignored while valid_o=0.

## Structure
- Package `period_meas_pkg`: state enum typedef (IDLE, ARMED), and a function returning the saturation constant for a given width.
- Sub-module `sat_counter`: parameter WIDTH; ports clk, rst, clr_load (loads 1), clear (loads 0), en; outputs count and at_max. Saturating increment.
- Top level contains the FSM, glitch compare, output register and drop logic.

## Test plan
- Reset, then evt at cycles 10, 25, 45 with ready_i=1 → no result at 10; period_o=15 valid at cycle 26; period_o=20 valid at 46; ovf_o=0; drop_o=0.
- WIDTH=4, evt at cycles 0 and 30 → period_o=15, ovf_o=1.
- MIN_PERIOD=5, evt at 0, 3, 8 → the edge at 3 is ignored; single result period_o=8.
- ready_i=0, edges at 0, 10, 20 → period_o holds 10; the result for 20 is dropped; drop_o=1. Raising ready_i then clears valid_o.
- Capture and handshake in the same cycle: valid_o stays 1, the new period loads, drop_o stays 0.
- en low for 5 cycles between edges → returns to IDLE; the next edge arms only; the following edge yields the interval from re-arm.
- rst asserted mid-count with a result held → all outputs return to 0 in the next cycle.

Source files
------------

// File: rtl/period_meas_pkg.sv
// Shared types and helpers for the period measurement stage.
package period_meas_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // Saturation value (all ones) of a w-bit counter.
  function automatic logic [63:0] sat_max(input int unsigned w);
    if (w >= 64) begin
      sat_max = '1;
    end else begin
      sat_max = (64'(1) << w) - 64'(1);
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (to 0) and reload (to 1).
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_load,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);
  import period_meas_pkg::*;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(sat_max(WIDTH));

  logic [WIDTH-1:0] inc_c;

  // Next value on an increment.
  always_comb begin
    inc_c = count + WIDTH'(1);
  end

  // Counter register; at_max is tracked alongside so it is registered too.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count  <= '0;
      at_max <= 1'b0;
    end else if (clr_load) begin
      count  <= WIDTH'(1);
      at_max <= 1'b0;
    end else if (en && !at_max) begin
      count  <= inc_c;
      at_max <= (inc_c == MAX_CNT);
    end
  end

endmodule

// File: rtl/period_meas.sv
// Measures clock cycles between accepted edge pulses and presents each
// interval on a single-entry valid/ready output register.
module period_meas #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MIN_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             evt,
  output logic [WIDTH-1:0] period_o,
  output logic             ovf_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             drop_o
);
  import period_meas_pkg::*;

  localparam logic [0:0]       ST_IDLE  = 1'(IDLE);
  localparam logic [0:0]       ST_ARMED = 1'(ARMED);
  localparam logic [WIDTH-1:0] MIN_CNT  = WIDTH'(MIN_PERIOD);

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic             cnt_clear;
  logic             cnt_load;
  logic             cnt_inc;
  logic             capture_c;
  logic [WIDTH-1:0] cnt;
  logic             cnt_at_max;

  sat_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_load (cnt_load),
    .clear    (cnt_clear),
    .en       (cnt_inc),
    .count    (cnt),
    .at_max   (cnt_at_max)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter control and edge acceptance (glitch filter).
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    capture_c = 1'b0;
    if (!en) begin
      state_d   = ST_IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (evt) begin
            state_d  = ST_ARMED;
            cnt_load = 1'b1;
          end else begin
            cnt_clear = 1'b1;
          end
        end
        ST_ARMED: begin
          if (evt && (cnt >= MIN_CNT)) begin
            capture_c = 1'b1;
            cnt_load  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // Single-entry result register with sticky loss flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_o <= '0;
      ovf_o    <= 1'b0;
      valid_o  <= 1'b0;
      drop_o   <= 1'b0;
    end else if (capture_c) begin
      if (!valid_o || ready_i) begin
        period_o <= cnt;
        ovf_o    <= cnt_at_max;
        valid_o  <= 1'b1;
      end else begin
        drop_o <= 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
